// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: register byte offsets,
// TCON bit positions and the offset-to-register decode helper.
package periph_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h4000_0000;

  localparam logic [4:0] OFS_TH      = 5'h00;
  localparam logic [4:0] OFS_TL      = 5'h04;
  localparam logic [4:0] OFS_TCON    = 5'h08;
  localparam logic [4:0] OFS_LED     = 5'h0C;
  localparam logic [4:0] OFS_SWITCH  = 5'h10;
  localparam logic [4:0] OFS_DIGI    = 5'h14;
  localparam logic [4:0] OFS_SYSTICK = 5'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_LED,
    REG_SWITCH,
    REG_DIGI,
    REG_SYSTICK,
    REG_NONE
  } reg_e;

  // Byte offset within the window -> register; byte lane bits are ignored.
  function automatic reg_e decode_offset(input logic [4:0] ofs, input logic systick_en);
    reg_e r;
    r = REG_NONE;
    case (ofs[4:2])
      OFS_TH[4:2]:      r = REG_TH;
      OFS_TL[4:2]:      r = REG_TL;
      OFS_TCON[4:2]:    r = REG_TCON;
      OFS_LED[4:2]:     r = REG_LED;
      OFS_SWITCH[4:2]:  r = REG_SWITCH;
      OFS_DIGI[4:2]:    r = REG_DIGI;
      OFS_SYSTICK[4:2]: r = systick_en ? REG_SYSTICK : REG_NONE;
      default:          r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// CPU data-memory port as seen by the peripheral block: address, store data,
// load/store strobes and the combinational load data returned to the CPU.
interface peripheral_bus_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (output Address, output Write_data, output MemRead, output MemWrite,
                  input  Read_data);
  modport slave  (input  Address, input  Write_data, input  MemRead, input  MemWrite,
                  output Read_data);
endinterface

// File: rtl/periph_timer.sv
// Reloading 32-bit timer: TH reload value, TL up-counter, TCON control/status.
// Raises a level interrupt when TL overflows with the interrupt enabled.
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        overflow;

  assign overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    th_d   = wr_th_i ? wdata_i : th_q;

    tl_d   = tl_q;
    if (wr_tl_i) begin
      tl_d = wdata_i;
    end else if (tcon_q[TCON_EN]) begin
      // Reload takes the TH currently held, even if TH is being written this same edge.
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end

    tcon_d = wr_tcon_i ? wdata_i[2:0] : tcon_q;
    // A software clear of the status bit loses to an overflow on the same edge.
    if (overflow && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Peripheral responder for the CPU data port: address decode, read mux, LED/DIGI registers.
// Define PERIPH_SYSTICK_EN to add a free-running SYSTICK counter at offset 0x18.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR_P = BASE_ADDR,
  parameter int          LED_W       = 8,
  parameter int          SW_W        = 8,
  parameter int          DIGI_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  peripheral_bus_if.slave   bus,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

`ifdef PERIPH_SYSTICK_EN
  localparam logic SYSTICK_EN = 1'b1;
`else
  localparam logic SYSTICK_EN = 1'b0;
`endif

  logic              in_window;
  reg_e              sel;
  logic [LED_W-1:0]  led_q;
  logic [DIGI_W-1:0] digi_q;
  logic [31:0]       th, tl;
  logic [2:0]        tcon;
  logic [31:0]       systick;
  logic [1:0]        unused_byte_lane;

  assign unused_byte_lane = bus.Address[1:0];
  assign in_window = (bus.Address[31:5] == BASE_ADDR_P[31:5]);
  assign sel       = in_window ? decode_offset(bus.Address[4:0], SYSTICK_EN) : REG_NONE;

  periph_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_th_i   (bus.MemWrite && sel == REG_TH),
    .wr_tl_i   (bus.MemWrite && sel == REG_TL),
    .wr_tcon_i (bus.MemWrite && sel == REG_TCON),
    .wdata_i   (bus.Write_data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irqout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else if (bus.MemWrite) begin
      if (sel == REG_LED)  led_q  <= bus.Write_data[LED_W-1:0];
      if (sel == REG_DIGI) digi_q <= bus.Write_data[DIGI_W-1:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_q + 32'd1;
  end

  assign systick = systick_q;
`else
  assign systick = '0;
`endif

  // Reads are combinational, so a simultaneous store is seen only from the next cycle.
  always_comb begin
    bus.Read_data = '0;
    if (bus.MemRead) begin
      case (sel)
        REG_TH:      bus.Read_data = th;
        REG_TL:      bus.Read_data = tl;
        REG_TCON:    bus.Read_data = 32'(tcon);
        REG_LED:     bus.Read_data = 32'(led_q);
        REG_SWITCH:  bus.Read_data = 32'(switch);
        REG_DIGI:    bus.Read_data = 32'(digi_q);
        REG_SYSTICK: bus.Read_data = systick;
        default:     bus.Read_data = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign digi = digi_q;

endmodule
